// File: rtl/processor.sv
// Single-cycle MIPS32 core: one instruction retires per rising clk edge.
// Define PROCESSOR_SHIFT_EN to add the sllv/srlv/srav R-type shifts.
module processor #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instruction,
    output logic        write_enable,
    output logic [31:0] address_to_mem,
    output logic [31:0] data_to_mem,
    input  logic [31:0] data_from_mem
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned RIDX  = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
`ifdef PROCESSOR_SHIFT_EN
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
`endif

    localparam logic [RIDX-1:0] RA_IDX = 5'd31;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] regs_q [NREGS];

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [RIDX-1:0] rs_idx, rt_idx, rd_idx;
    logic [15:0]     imm;

    logic [XLEN-1:0] rs_val, rt_val;
    logic [XLEN-1:0] imm_se, imm_ze;
    logic [XLEN-1:0] pc_plus4, branch_target, jump_target;

    logic            rf_we;
    logic [RIDX-1:0] rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            is_store;

    // Instruction field decode and combinational register reads ($0 hardwired).
    always_comb begin
        opcode = instruction[31:26];
        rs_idx = instruction[25:21];
        rt_idx = instruction[20:16];
        rd_idx = instruction[15:11];
        funct  = instruction[5:0];
        imm    = instruction[15:0];
        rs_val = (rs_idx == '0) ? '0 : regs_q[rs_idx];
        rt_val = (rt_idx == '0) ? '0 : regs_q[rt_idx];
        imm_se = {{16{imm[15]}}, imm};
        imm_ze = {16'h0000, imm};
    end

    // Execute: next PC, writeback selection and store strobe.
    always_comb begin
        pc_plus4      = pc_q + XLEN'(4);
        branch_target = pc_plus4 + {imm_se[XLEN-3:0], 2'b00};
        jump_target   = {pc_plus4[31:28], instruction[25:0], 2'b00};
        pc_d          = pc_plus4;
        rf_we         = 1'b0;
        rf_waddr      = '0;
        rf_wdata      = '0;
        is_store      = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                rf_waddr = rd_idx;
                case (funct)
                    FN_ADD: begin rf_we = 1'b1; rf_wdata = rs_val + rt_val; end
                    FN_SUB: begin rf_we = 1'b1; rf_wdata = rs_val - rt_val; end
                    FN_AND: begin rf_we = 1'b1; rf_wdata = rs_val & rt_val; end
                    FN_OR:  begin rf_we = 1'b1; rf_wdata = rs_val | rt_val; end
                    FN_SLT: begin
                        rf_we    = 1'b1;
                        rf_wdata = {31'd0, ($signed(rs_val) < $signed(rt_val))};
                    end
                    FN_JR:  pc_d = rs_val;
`ifdef PROCESSOR_SHIFT_EN
                    FN_SLLV: begin rf_we = 1'b1; rf_wdata = rt_val << rs_val[4:0]; end
                    FN_SRLV: begin rf_we = 1'b1; rf_wdata = rt_val >> rs_val[4:0]; end
                    FN_SRAV: begin
                        rf_we    = 1'b1;
                        rf_wdata = XLEN'($signed(rt_val) >>> rs_val[4:0]);
                    end
`endif
                    default: ;
                endcase
            end
            OP_J:    pc_d = jump_target;
            OP_JAL: begin
                pc_d     = jump_target;
                rf_we    = 1'b1;
                rf_waddr = RA_IDX;
                rf_wdata = pc_plus4;
            end
            OP_BEQ:  if (rs_val == rt_val) pc_d = branch_target;
            OP_BNE:  if (rs_val != rt_val) pc_d = branch_target;
            OP_ADDI: begin rf_we = 1'b1; rf_waddr = rt_idx; rf_wdata = rs_val + imm_se; end
            OP_ORI:  begin rf_we = 1'b1; rf_waddr = rt_idx; rf_wdata = rs_val | imm_ze; end
            OP_LUI:  begin rf_we = 1'b1; rf_waddr = rt_idx; rf_wdata = {imm, 16'h0000}; end
            OP_LW:   begin rf_we = 1'b1; rf_waddr = rt_idx; rf_wdata = data_from_mem; end
            OP_SW:   is_store = 1'b1;
            default: ;
        endcase
    end

    // PC and register file; reset aborts the in-flight instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pc_q <= pc_d;
            if (rf_we && (rf_waddr != '0)) begin
                regs_q[rf_waddr] <= rf_wdata;
            end
        end
    end

    assign pc             = pc_q;
    assign write_enable   = is_store & reset;
    assign address_to_mem = rs_val + imm_se;
    assign data_to_mem    = rt_val;

endmodule

// File: tb/tb_processor.sv
// Bench for processor: small programs in a model instruction memory, with
// every expected store queued when the program is loaded and popped on write.
module tb_processor;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        write_enable;
    logic [31:0] address_to_mem;
    logic [31:0] data_to_mem;
    logic [31:0] data_from_mem;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } store_t;

    store_t sb[$];
    int     n_checks = 0;
    int     n_errors = 0;

    processor dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .instruction   (instruction),
        .write_enable  (write_enable),
        .address_to_mem(address_to_mem),
        .data_to_mem   (data_to_mem),
        .data_from_mem (data_from_mem)
    );

    assign instruction   = imem[pc[7:2]];
    assign data_from_mem = dmem[address_to_mem[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write_enable) dmem[address_to_mem[7:2]] <= data_to_mem;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Every store the core makes must match the next queued expectation.
    always @(negedge clk) begin
        store_t e;
        if (write_enable !== 1'b0) begin
            if (sb.size() == 0) begin
                check("store_unexpected", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("store_addr", address_to_mem, e.addr);
                check("store_data", data_to_mem, e.data);
            end
        end
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    localparam logic [5:0] ADDI = 6'h08, ORI = 6'h0D, LUI = 6'h0F, LW = 6'h23, SW = 6'h2B;
    localparam logic [5:0] BEQ = 6'h04, BNE = 6'h05, J = 6'h02, JAL = 6'h03;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A, F_JR = 6'h08;
    localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    task automatic expect_store(input logic [31:0] a, input logic [31:0] d);
        store_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Release after a rising edge so the next negedge still sees RESET_PC.
    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        step(1);
        check("first_pc", pc, 32'h0);
    endtask

    task automatic load_a();
        clear_imem();
        imem[0]  = enc_i(ADDI, 0, 2, 16'd5);
        imem[1]  = enc_i(ADDI, 0, 3, 16'd12);
        imem[2]  = enc_i(ADDI, 0, 0, 16'd9);
        imem[3]  = enc_i(SW, 0, 2, 16'd0);   expect_store(32'd0, 32'd5);
        imem[4]  = enc_i(SW, 0, 3, 16'd4);   expect_store(32'd4, 32'd12);
        imem[5]  = enc_i(SW, 0, 0, 16'd8);   expect_store(32'd8, 32'd0);
        imem[6]  = enc_i(ADDI, 0, 3, 16'd7);
        imem[7]  = enc_i(SW, 0, 3, 16'd84);  expect_store(32'd84, 32'd7);
        imem[8]  = enc_i(LW, 0, 4, 16'd84);
        imem[9]  = enc_i(SW, 0, 4, 16'd12);  expect_store(32'd12, 32'd7);
        imem[10] = enc_i(ADDI, 0, 5, 16'hFFFF);
        imem[11] = enc_i(ADDI, 0, 6, 16'd1);
        imem[12] = enc_r(5, 6, 7, F_SLT);
        imem[13] = enc_i(SW, 0, 7, 16'd16);  expect_store(32'd16, 32'd1);
        imem[14] = enc_r(6, 5, 8, F_SLT);
        imem[15] = enc_i(SW, 0, 8, 16'd20);  expect_store(32'd20, 32'd0);
        imem[16] = enc_i(LUI, 0, 9, 16'h1234);
        imem[17] = enc_i(ORI, 9, 9, 16'h5678);
        imem[18] = enc_i(SW, 0, 9, 16'd24);  expect_store(32'd24, 32'h1234_5678);
        imem[19] = enc_r(9, 5, 10, F_ADD);
        imem[20] = enc_i(SW, 0, 10, 16'd28); expect_store(32'd28, 32'h1234_5677);
        imem[21] = enc_r(0, 6, 11, F_SUB);
        imem[22] = enc_i(SW, 0, 11, 16'd32); expect_store(32'd32, 32'hFFFF_FFFF);
        imem[23] = enc_r(10, 9, 12, F_AND);
        imem[24] = enc_i(SW, 0, 12, 16'd36); expect_store(32'd36, 32'h1234_5670);
        imem[25] = enc_r(9, 6, 13, F_OR);
        imem[26] = enc_i(SW, 0, 13, 16'd40); expect_store(32'd40, 32'h1234_5679);
        imem[27] = enc_i(LUI, 0, 14, 16'h8000);
        imem[28] = enc_i(ADDI, 0, 15, 16'd4);
        imem[29] = enc_i(ADDI, 0, 16, 16'h0055);
        imem[30] = enc_i(ADDI, 0, 17, 16'h0055);
        imem[31] = enc_i(ADDI, 0, 18, 16'h0055);
        imem[32] = enc_r(15, 14, 16, F_SRAV);
        imem[33] = enc_r(15, 14, 17, F_SRLV);
        imem[34] = enc_r(15, 15, 18, F_SLLV);
        imem[35] = enc_i(SW, 0, 16, 16'd44);
        imem[36] = enc_i(SW, 0, 17, 16'd48);
        imem[37] = enc_i(SW, 0, 18, 16'd52);
`ifdef PROCESSOR_SHIFT_EN
        expect_store(32'd44, 32'hF800_0000);
        expect_store(32'd48, 32'h0800_0000);
        expect_store(32'd52, 32'h0000_0040);
`else
        expect_store(32'd44, 32'h0000_0055);
        expect_store(32'd48, 32'h0000_0055);
        expect_store(32'd52, 32'h0000_0055);
`endif
        imem[38] = enc_r(14, 14, 20, F_ADD);
        imem[39] = enc_i(SW, 0, 20, 16'd56); expect_store(32'd56, 32'd0);
        imem[40] = enc_i(6'h3F, 0, 21, 16'd7);
        imem[41] = enc_r(6, 6, 22, 6'h3F);
        imem[42] = enc_i(SW, 0, 21, 16'd60); expect_store(32'd60, 32'd0);
        imem[43] = enc_i(SW, 0, 22, 16'd64); expect_store(32'd64, 32'd0);
        imem[44] = enc_i(ADDI, 0, 23, 16'hFFFC);
        imem[45] = enc_i(SW, 23, 6, 16'd72); expect_store(32'd68, 32'd1);
        imem[46] = enc_i(BEQ, 0, 0, 16'hFFFF);
    endtask

    task automatic load_b();
        clear_imem();
        imem[0]  = enc_i(ADDI, 0, 1, 16'd3);
        imem[1]  = enc_i(ADDI, 0, 2, 16'd3);
        imem[2]  = enc_i(ADDI, 0, 3, 16'd4);
        imem[4]  = enc_i(BEQ, 1, 2, 16'd2);
        imem[5]  = enc_i(SW, 0, 1, 16'h30);
        imem[6]  = enc_i(SW, 0, 1, 16'h34);
        imem[7]  = enc_i(BEQ, 1, 3, 16'd2);
        imem[8]  = enc_j(JAL, 26'h000010);
        imem[9]  = enc_i(SW, 0, 31, 16'd0);  expect_store(32'd0, 32'h24);
        imem[10] = enc_i(BNE, 1, 3, 16'd2);
        imem[11] = enc_i(SW, 0, 1, 16'h38);
        imem[12] = enc_i(SW, 0, 1, 16'h3C);
        imem[13] = enc_i(BNE, 1, 2, 16'd5);
        imem[14] = enc_j(J, 26'h000012);
        imem[15] = enc_i(SW, 0, 1, 16'h40);
        imem[16] = enc_r(31, 0, 0, F_JR);
        imem[17] = enc_i(SW, 0, 1, 16'h44);
        imem[18] = enc_i(SW, 0, 3, 16'd4);   expect_store(32'd4, 32'd4);
        imem[19] = enc_i(BEQ, 0, 0, 16'hFFFF);
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
        load_a();
        step(2);
        check("reset_pc", pc, 32'h0);
        check("reset_we", {31'd0, write_enable}, 32'd0);

        // Program A: ALU, memory, $0, shifts, unsupported codes.
        release_reset();
        step(2);
        check("addi_pc", pc, 32'h8);
        check("addi_we", {31'd0, write_enable}, 32'd0);
        step(48);
        check("prog_a_end_pc", pc, 32'hB8);

        // Asynchronous reset mid-run, then verify all registers cleared.
        #2 reset = 1'b0;
        #1 check("async_reset_pc", pc, 32'h0);
        clear_imem();
        imem[0] = enc_i(SW, 0, 4, 16'd0);   expect_store(32'd0, 32'd0);
        imem[1] = enc_i(SW, 0, 9, 16'd4);   expect_store(32'd4, 32'd0);
        imem[2] = enc_i(SW, 0, 16, 16'd8);  expect_store(32'd8, 32'd0);
        imem[3] = enc_i(SW, 0, 23, 16'd12); expect_store(32'd12, 32'd0);
        imem[4] = enc_i(BEQ, 0, 0, 16'hFFFF);
        #1 check("reset_forces_we", {31'd0, write_enable}, 32'd0);
        step(2);
        check("reset_hold_pc", pc, 32'h0);
        release_reset();
        step(6);
        check("prog_d_end_pc", pc, 32'h10);

        // Program B: branches, jal/jr, j.
        reset = 1'b0;
        load_b();
        step(1);
        release_reset();
        step(5); check("beq_taken_pc", pc, 32'h1C);
        step(1); check("beq_not_taken_pc", pc, 32'h20);
        step(1); check("jal_pc", pc, 32'h40);
        step(1); check("jr_pc", pc, 32'h24);
        step(2); check("bne_taken_pc", pc, 32'h34);
        step(2); check("j_pc", pc, 32'h48);
        step(2); check("beq_back_pc", pc, 32'h4C);
        step(1); check("self_loop_pc", pc, 32'h4C);

        // Program C: jr target keeps its low bits.
        reset = 1'b0;
        clear_imem();
        imem[0]  = enc_i(ADDI, 0, 20, 16'h0051);
        imem[1]  = enc_r(20, 0, 0, F_JR);
        imem[20] = enc_i(SW, 0, 20, 16'd0); expect_store(32'd0, 32'h51);
        imem[21] = enc_i(BEQ, 0, 0, 16'hFFFF);
        step(1);
        release_reset();
        step(2); check("jr_unaligned_pc", pc, 32'h51);
        step(3); check("post_jr_pc", pc, 32'h55);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
